// File: rtl/hs_ad_capture_ctrl.sv
// Dual-channel ADC acquisition controller: input registering, decimation,
// armed level/edge trigger and fixed-length block write into external SDP RAM.
module hs_ad_capture_ctrl #(
  parameter int DEPTH_W = 10,
  parameter int DEC_W   = 8
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [9:0]         ad0_data,
  input  logic               ad0_otr,
  input  logic [9:0]         ad1_data,
  input  logic               ad1_otr,
  input  logic               start,
  input  logic               abort,
  input  logic               force_trig,
  input  logic               trig_sel,
  input  logic               trig_edge,
  input  logic [9:0]         trig_level,
  input  logic [DEC_W-1:0]   dec_ratio,
  output logic               wr_en,
  output logic [DEPTH_W-1:0] wr_addr,
  output logic [19:0]        wr_data,
  output logic               busy,
  output logic               waiting,
  output logic               done,
  output logic               otr_flag
);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT_TRIG,
    CAPTURE,
    DONE
  } state_t;

  localparam logic [DEPTH_W-1:0] ADDR_ONE  = 1;
  localparam logic [DEPTH_W-1:0] ADDR_LAST = '1;
  localparam logic [DEC_W-1:0]   DEC_ONE   = 1;

  state_t             state;
  logic [9:0]         s1_ad0;
  logic [9:0]         s1_ad1;
  logic               s1_otr0;
  logic               s1_otr1;
  logic [DEC_W-1:0]   dec_ratio_q;
  logic [DEC_W-1:0]   dec_cnt;
  logic               trig_sel_q;
  logic               trig_edge_q;
  logic [9:0]         trig_level_q;
  logic [9:0]         prev;
  logic [DEPTH_W-1:0] cap_cnt;

  logic       start_ok;
  logic       stb;
  logic [9:0] cur;
  logic       rise_hit;
  logic       fall_hit;
  logic       hit;

  // S1 input stage; trigger compare and RAM write both use these values.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s1_ad0  <= '0;
      s1_ad1  <= '0;
      s1_otr0 <= 1'b0;
      s1_otr1 <= 1'b0;
    end else begin
      s1_ad0  <= ad0_data;
      s1_ad1  <= ad1_data;
      s1_otr0 <= ad0_otr;
      s1_otr1 <= ad1_otr;
    end
  end

  assign start_ok = start && !abort && ((state == IDLE) || (state == DONE));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      dec_ratio_q  <= '0;
      trig_sel_q   <= 1'b0;
      trig_edge_q  <= 1'b0;
      trig_level_q <= '0;
    end else if (start_ok) begin
      dec_ratio_q  <= dec_ratio;
      trig_sel_q   <= trig_sel;
      trig_edge_q  <= trig_edge;
      trig_level_q <= trig_level;
    end
  end

  // Restarting at 0 on arm makes the first ARM cycle a strobe.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      dec_cnt <= '0;
    end else if (start_ok) begin
      dec_cnt <= '0;
    end else if (dec_cnt >= dec_ratio_q) begin
      dec_cnt <= '0;
    end else begin
      dec_cnt <= dec_cnt + DEC_ONE;
    end
  end

  assign stb      = (dec_cnt == '0);
  assign cur      = trig_sel_q ? s1_ad1 : s1_ad0;
  assign rise_hit = (prev < trig_level_q) && (cur >= trig_level_q);
  assign fall_hit = (prev > trig_level_q) && (cur <= trig_level_q);
  assign hit      = trig_edge_q ? fall_hit : rise_hit;

  // wr_addr advances the cycle after each visible write, so it always shows
  // the address of the strobe currently on the RAM port.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
      waiting  <= 1'b0;
      done     <= 1'b0;
      otr_flag <= 1'b0;
      prev     <= '0;
      cap_cnt  <= '0;
    end else begin
      wr_en <= 1'b0;
      if (abort) begin
        state   <= IDLE;
        busy    <= 1'b0;
        waiting <= 1'b0;
        done    <= 1'b0;
      end else begin
        if (wr_en) begin
          wr_addr <= wr_addr + ADDR_ONE;
        end
        case (state)
          IDLE: begin
            if (start) begin
              state    <= ARM;
              wr_addr  <= '0;
              otr_flag <= 1'b0;
              done     <= 1'b0;
              busy     <= 1'b1;
              waiting  <= 1'b0;
            end
          end
          ARM: begin
            if (stb) begin
              prev    <= cur;
              state   <= WAIT_TRIG;
              waiting <= 1'b1;
            end
          end
          WAIT_TRIG: begin
            if (stb) begin
              prev <= cur;
              if (hit || force_trig) begin
                state   <= CAPTURE;
                waiting <= 1'b0;
                wr_en   <= 1'b1;
                wr_data <= {s1_ad1, s1_ad0};
                if (s1_otr0 || s1_otr1) begin
                  otr_flag <= 1'b1;
                end
                cap_cnt <= ADDR_ONE;
              end
            end
          end
          CAPTURE: begin
            if (stb) begin
              wr_en   <= 1'b1;
              wr_data <= {s1_ad1, s1_ad0};
              if (s1_otr0 || s1_otr1) begin
                otr_flag <= 1'b1;
              end
              cap_cnt <= cap_cnt + ADDR_ONE;
              if (cap_cnt == ADDR_LAST) begin
                state <= DONE;
              end
            end
          end
          DONE: begin
            if (start) begin
              state    <= ARM;
              wr_addr  <= '0;
              otr_flag <= 1'b0;
              done     <= 1'b0;
              busy     <= 1'b1;
              waiting  <= 1'b0;
            end else begin
              // Final write is still on the port during the first DONE cycle.
              done <= 1'b1;
              busy <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hs_ad_capture_ctrl.sv
// Directed bench for hs_ad_capture_ctrl: rising/falling/forced triggers,
// decimation spacing, otr stickiness, abort, ignored start and mid-capture reset.
module tb_hs_ad_capture_ctrl;

  localparam int DEPTH_W = 10;
  localparam int DEC_W   = 8;

  logic               sys_clk = 1'b0;
  logic               sys_rst_n;
  logic [9:0]         ad0_data;
  logic               ad0_otr;
  logic [9:0]         ad1_data;
  logic               ad1_otr;
  logic               start;
  logic               abort;
  logic               force_trig;
  logic               trig_sel;
  logic               trig_edge;
  logic [9:0]         trig_level;
  logic [DEC_W-1:0]   dec_ratio;
  logic               wr_en;
  logic [DEPTH_W-1:0] wr_addr;
  logic [19:0]        wr_data;
  logic               busy;
  logic               waiting;
  logic               done;
  logic               otr_flag;

  always #5 sys_clk = ~sys_clk;

  hs_ad_capture_ctrl #(.DEPTH_W(DEPTH_W), .DEC_W(DEC_W)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .ad0_data   (ad0_data),
    .ad0_otr    (ad0_otr),
    .ad1_data   (ad1_data),
    .ad1_otr    (ad1_otr),
    .start      (start),
    .abort      (abort),
    .force_trig (force_trig),
    .trig_sel   (trig_sel),
    .trig_edge  (trig_edge),
    .trig_level (trig_level),
    .dec_ratio  (dec_ratio),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .waiting    (waiting),
    .done       (done),
    .otr_flag   (otr_flag)
  );

  int total = 0;
  int bad   = 0;

  int cyc = 0;
  int nwr;
  int first_cyc;
  int last_cyc;
  int done_cyc;
  int seq_err;
  int exp_gap;
  int mode;
  int step_ctr;
  int mark;
  logic [DEPTH_W-1:0] first_addr;
  logic [DEPTH_W-1:0] last_addr;
  logic [19:0]        first_data;
  logic               otr_at36;
  logic               otr_at37;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clearLog(input int gap);
    nwr       = 0;
    seq_err   = 0;
    exp_gap   = gap;
    first_cyc = -1;
    last_cyc  = -1;
    done_cyc  = -1;
    otr_at36  = 1'bx;
    otr_at37  = 1'bx;
  endtask

  // One clock: observe outputs 1 time unit after the edge, log writes, then
  // advance the data pattern selected by mode.
  task automatic applyStimulus();
    logic [DEPTH_W-1:0] next_addr;
    @(posedge sys_clk);
    #1;
    cyc++;
    if (wr_en === 1'b1) begin
      if (nwr == 0) begin
        first_cyc  = cyc;
        first_addr = wr_addr;
        first_data = wr_data;
      end else begin
        next_addr = last_addr + 1'b1;
        if ((wr_addr !== next_addr) || ((cyc - last_cyc) != exp_gap)) seq_err++;
      end
      if (nwr == 36) otr_at36 = otr_flag;
      if (nwr == 37) otr_at37 = otr_flag;
      last_cyc  = cyc;
      last_addr = wr_addr;
      nwr++;
    end
    if ((done === 1'b1) && (done_cyc < 0)) done_cyc = cyc;
    case (mode)
      1: ad0_data = ad0_data + 10'd1;
      2: begin
        step_ctr++;
        if (step_ctr == 4) begin
          step_ctr = 0;
          ad1_data = ad1_data - 10'd10;
        end
      end
      default: ;
    endcase
  endtask

  task automatic pulseStart();
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
  endtask

  task automatic pulseForce();
    force_trig = 1'b1;
    applyStimulus();
    force_trig = 1'b0;
  endtask

  task automatic runUntilDone(input int limit);
    int n = 0;
    while ((done !== 1'b1) && (n < limit)) begin
      applyStimulus();
      n++;
    end
  endtask

  task automatic runUntilWrites(input int k, input int limit);
    int n = 0;
    while ((nwr < k) && (n < limit)) begin
      applyStimulus();
      n++;
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    sys_rst_n  = 1'b0;
    ad0_data   = '0;
    ad0_otr    = 1'b0;
    ad1_data   = '0;
    ad1_otr    = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    force_trig = 1'b0;
    trig_sel   = 1'b0;
    trig_edge  = 1'b0;
    trig_level = 10'd512;
    dec_ratio  = '0;
    mode       = 0;
    step_ctr   = 0;
    clearLog(1);

    repeat (3) @(posedge sys_clk);
    #1;
    checkOutput("rst_flags", {27'd0, busy, waiting, done, otr_flag, wr_en}, 32'd0);
    checkOutput("rst_addr", {22'd0, wr_addr}, 32'd0);
    checkOutput("rst_data", {12'd0, wr_data}, 32'd0);
    sys_rst_n = 1'b1;
    repeat (2) applyStimulus();

    // Rising trigger on ch0 ramp, every cycle kept
    dec_ratio  = 8'd0;
    trig_level = 10'd512;
    trig_sel   = 1'b0;
    trig_edge  = 1'b0;
    ad0_data   = 10'd0;
    clearLog(1);
    pulseStart();
    checkOutput("A_busy_after_start", {31'd0, busy}, 32'd1);
    mode = 1;
    repeat (2) applyStimulus();
    checkOutput("A_waiting", {31'd0, waiting}, 32'd1);
    runUntilDone(3000);
    mode = 0;
    checkOutput("A_done", {31'd0, done}, 32'd1);
    checkOutput("A_busy_low", {31'd0, busy}, 32'd0);
    checkOutput("A_nwr", nwr, 32'd1024);
    checkOutput("A_first_addr", {22'd0, first_addr}, 32'd0);
    checkOutput("A_first_ch0", {22'd0, first_data[9:0]}, 32'd512);
    checkOutput("A_seq", seq_err, 32'd0);
    checkOutput("A_last_addr", {22'd0, last_addr}, 32'd1023);
    checkOutput("A_done_lat", done_cyc - last_cyc, 32'd1);
    checkOutput("A_otr", {31'd0, otr_flag}, 32'd0);

    // Falling trigger on ch1, decimate by 4, otr on write 37
    trig_sel   = 1'b1;
    trig_edge  = 1'b1;
    trig_level = 10'd300;
    dec_ratio  = 8'd3;
    ad0_data   = 10'd5;
    ad1_data   = 10'd400;
    step_ctr   = 0;
    clearLog(4);
    pulseStart();
    dec_ratio  = 8'd7;
    trig_level = 10'd0;
    mode       = 2;
    runUntilWrites(1, 400);
    mark = 0;
    while ((first_cyc >= 0) && (cyc < first_cyc + 4 * 37 - 2) && (mark < 400)) begin
      applyStimulus();
      mark++;
    end
    ad1_otr = 1'b1;
    applyStimulus();
    ad1_otr = 1'b0;
    runUntilDone(5000);
    mode = 0;
    checkOutput("B_done", {31'd0, done}, 32'd1);
    checkOutput("B_nwr", nwr, 32'd1024);
    checkOutput("B_first_ch1", {22'd0, first_data[19:10]}, 32'd300);
    checkOutput("B_seq", seq_err, 32'd0);
    checkOutput("B_span", last_cyc - first_cyc, 32'd4092);
    checkOutput("B_last_addr", {22'd0, last_addr}, 32'd1023);
    checkOutput("B_otr_w36", {31'd0, otr_at36}, 32'd0);
    checkOutput("B_otr_w37", {31'd0, otr_at37}, 32'd1);
    checkOutput("B_otr_done", {31'd0, otr_flag}, 32'd1);

    // No crossing, forced trigger, then abort at write 500
    trig_sel   = 1'b0;
    trig_edge  = 1'b0;
    trig_level = 10'd512;
    dec_ratio  = 8'd0;
    ad0_data   = 10'd700;
    clearLog(1);
    pulseStart();
    checkOutput("C_otr_clear", {31'd0, otr_flag}, 32'd0);
    checkOutput("C_done_clear", {31'd0, done}, 32'd0);
    repeat (20) applyStimulus();
    checkOutput("C_waiting", {31'd0, waiting}, 32'd1);
    checkOutput("C_no_write", nwr, 32'd0);
    mark = cyc;
    pulseForce();
    checkOutput("C_force_lat", first_cyc - mark, 32'd1);
    checkOutput("C_first_ch0", {22'd0, first_data[9:0]}, 32'd700);
    runUntilWrites(500, 1000);
    abort = 1'b1;
    applyStimulus();
    abort = 1'b0;
    checkOutput("C_abort_flags", {28'd0, busy, waiting, done, wr_en}, 32'd0);
    repeat (20) applyStimulus();
    checkOutput("C_abort_nwr", nwr, 32'd500);
    checkOutput("C_abort_last", {22'd0, last_addr}, 32'd499);

    // Start while busy must not disturb the capture
    clearLog(1);
    pulseStart();
    repeat (3) applyStimulus();
    pulseForce();
    runUntilWrites(300, 1000);
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
    runUntilDone(2000);
    checkOutput("D_done", {31'd0, done}, 32'd1);
    checkOutput("D_nwr", nwr, 32'd1024);
    checkOutput("D_seq", seq_err, 32'd0);
    checkOutput("D_last_addr", {22'd0, last_addr}, 32'd1023);

    // Asynchronous reset at write 100
    clearLog(1);
    pulseStart();
    repeat (3) applyStimulus();
    pulseForce();
    runUntilWrites(100, 500);
    sys_rst_n = 1'b0;
    #1;
    checkOutput("E_rst_flags", {27'd0, busy, waiting, done, otr_flag, wr_en}, 32'd0);
    checkOutput("E_rst_addr", {22'd0, wr_addr}, 32'd0);
    checkOutput("E_rst_data", {12'd0, wr_data}, 32'd0);
    repeat (2) applyStimulus();
    sys_rst_n = 1'b1;
    repeat (30) applyStimulus();
    checkOutput("E_no_more_writes", nwr, 32'd100);
    checkOutput("E_idle", {30'd0, busy, waiting}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
